// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter:
// FSM state encoding, legal oversampling ratios and parity-type encoding.
package uart_pkg;

  // One-hot frame states; any other encoding is treated as illegal.
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } uart_state_e;

  // Parity type selector as seen on PAR_TYP.
  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_e;

  // Oversampling ratios the sampler is designed around.
  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Two-out-of-three vote used to reject single-sample line noise.
  function automatic logic majority3(input logic [2:0] samples);
    return (samples[0] & samples[1]) |
           (samples[0] & samples[2]) |
           (samples[1] & samples[2]);
  endfunction

  // Expected parity bit for a data word under the selected parity type.
  function automatic logic expectedParity(input logic dataXor, input parity_e parTyp);
    return (parTyp == PAR_ODD) ? ~dataXor : dataXor;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: counts oversampling edges inside a bit
// period and produces a majority-voted bit value from three mid-bit samples.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       run_i,
  input  logic [5:0] prescale_i,
  input  logic       rx_i,
  output logic       bitDone_o,
  output logic       voteValid_o,
  output logic       voteBit_o
);

  logic [5:0] edgeCnt_q;
  logic [5:0] edgeCnt_d;
  logic [2:0] samples_q;
  logic [2:0] samples_d;
  logic [5:0] halfCnt;
  logic [5:0] lastCnt;

  assign halfCnt = {1'b0, prescale_i[5:1]};
  assign lastCnt = prescale_i - 6'd1;

  // Next edge count: held at zero while idle, wraps at the bit boundary.
  always_comb begin
    edgeCnt_d = edgeCnt_q;
    if (!run_i) begin
      edgeCnt_d = 6'd0;
    end else if (edgeCnt_q == lastCnt) begin
      edgeCnt_d = 6'd0;
    end else begin
      edgeCnt_d = edgeCnt_q + 6'd1;
    end
  end

  // Capture the line one edge before, at, and one edge after mid-bit.
  always_comb begin
    samples_d = samples_q;
    if (run_i) begin
      if (edgeCnt_q == halfCnt - 6'd1) begin
        samples_d[0] = rx_i;
      end
      if (edgeCnt_q == halfCnt) begin
        samples_d[1] = rx_i;
      end
      if (edgeCnt_q == halfCnt + 6'd1) begin
        samples_d[2] = rx_i;
      end
    end
  end

  // Edge counter and sample registers; samples idle high like the line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edgeCnt_q <= 6'd0;
      samples_q <= 3'b111;
    end else begin
      edgeCnt_q <= edgeCnt_d;
      samples_q <= samples_d;
    end
  end

  // The stored samples stay stable until the next bit's first sample, so
  // the vote can be used anywhere from half+2 up to the bit boundary.
  assign voteBit_o   = majority3(samples_q);
  assign voteValid_o = run_i && (edgeCnt_q == halfCnt + 6'd2);
  assign bitDone_o   = run_i && (edgeCnt_q == lastCnt);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line, walks the frame FSM, assembles
// the data word LSB first, checks optional parity and the stop bit, and emits
// single-cycle result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic [1:0]            sync_q;
  logic                  rxS;
  uart_state_e           state_q;
  logic [5:0]            prescale_q;
  logic                  parEn_q;
  parity_e               parTyp_q;
  logic [BIT_W-1:0]      bitCnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  parErr_q;
  logic [DATA_WIDTH-1:0] pData_q;
  logic                  dataValid_q;
  logic                  parErrPulse_q;
  logic                  stpErr_q;

  logic                  sampleRun;
  logic                  bitDone;
  logic                  voteValid;
  logic                  voteBit;
  logic                  parityBit;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end

  assign rxS = sync_q[1];

  // Edge counting only runs while a frame is in progress.
  assign sampleRun = (state_q != IDLE);

  uart_rx_sampler u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .run_i       (sampleRun),
    .prescale_i  (prescale_q),
    .rx_i        (rxS),
    .bitDone_o   (bitDone),
    .voteValid_o (voteValid),
    .voteBit_o   (voteBit)
  );

  assign parityBit = expectedParity(^shift_q, parTyp_q);

  // Frame FSM with bit counter, shift register, parity latch and result pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      prescale_q    <= PRESCALE_16;
      parEn_q       <= 1'b0;
      parTyp_q      <= PAR_EVEN;
      bitCnt_q      <= '0;
      shift_q       <= '0;
      parErr_q      <= 1'b0;
      pData_q       <= '0;
      dataValid_q   <= 1'b0;
      parErrPulse_q <= 1'b0;
      stpErr_q      <= 1'b0;
    end else begin
      dataValid_q   <= 1'b0;
      parErrPulse_q <= 1'b0;
      stpErr_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxS) begin
            state_q    <= START;
            prescale_q <= PRESCALE;
            parEn_q    <= PAR_EN;
            parTyp_q   <= parity_e'(PAR_TYP);
            bitCnt_q   <= '0;
            parErr_q   <= 1'b0;
          end
        end
        START: begin
          if (bitDone) begin
            state_q <= voteBit ? IDLE : DATA;
          end
        end
        DATA: begin
          if (voteValid) begin
            shift_q[bitCnt_q] <= voteBit;
          end
          if (bitDone) begin
            if (bitCnt_q == LAST_BIT) begin
              bitCnt_q <= '0;
              state_q  <= parEn_q ? PARITY : STOP;
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (voteValid && (voteBit != parityBit)) begin
            parErr_q <= 1'b1;
          end
          if (bitDone) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (voteValid) begin
            state_q       <= IDLE;
            stpErr_q      <= ~voteBit;
            parErrPulse_q <= parErr_q;
            if (voteBit && !parErr_q) begin
              dataValid_q <= 1'b1;
              pData_q     <= shift_q;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          bitCnt_q <= '0;
          parErr_q <= 1'b0;
        end
      endcase
    end
  end

  assign P_DATA     = pData_q;
  assign DATA_VALID = dataValid_q;
  assign PAR_ERR    = parErrPulse_q;
  assign STP_ERR    = stpErr_q;

endmodule
